// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op encodings, FSM states and the flag bundle.
// Optional multiplier is enabled by defining ALU_MUL_EN.
package alu_seq_pkg;

    localparam logic [3:0] OP_ABS = 4'd0;
    localparam logic [3:0] OP_SHL = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_ADD = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_e;

    typedef struct packed {
        logic carry;
        logic sign;
        logic ov;
        logic zero;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_seq_mul #(
    parameter int unsigned WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    import alu_seq_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q, acc_next;
    logic [WIDTH-1:0]     mplier_q;

    // Add the current shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Operand capture on start, then one shift-add step per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Final step's sum is presented directly so the top can latch it on the last count.
    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_next;

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and registered flags.
// Define ALU_MUL_EN to include the iterative multiplier (op 8); otherwise op 8 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             sign,
    output logic             ov,
    output logic             zero,
    output logic             err
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] z_q, z_d, alu_z;
    flags_t           flags_q, flags_d, alu_f;
    logic [WIDTH:0]   sum;
    logic             accept;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign accept    = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    flags_t             mul_f;

    assign mul_start = accept && (op == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Flags for the multiplier result; overflow mirrors a non-zero high half.
    always_comb begin
        mul_f       = '0;
        mul_f.carry = |mul_prod[2*WIDTH-1:WIDTH];
        mul_f.ov    = mul_f.carry;
        mul_f.sign  = mul_prod[WIDTH-1];
        mul_f.zero  = (mul_prod[WIDTH-1:0] == '0);
    end
`endif

    // Single-cycle datapath: result and flags straight from the request operands.
    always_comb begin
        alu_z = '0;
        alu_f = '0;
        sum   = '0;
        case (op)
            OP_ABS: begin
                alu_z    = a[WIDTH-1] ? ('0 - a) : a;
                alu_f.ov = (a == MIN_NEG);
            end
            OP_SHL: begin
                alu_z       = {b[WIDTH-2:0], 1'b0};
                alu_f.carry = b[WIDTH-1];
                alu_f.ov    = b[WIDTH-1] ^ b[WIDTH-2];
            end
            OP_AND: alu_z = a & b;
            OP_OR:  alu_z = a | b;
            OP_XOR: alu_z = a ^ b;
            OP_NOT: alu_z = ~a;
            OP_ADD: begin
                sum         = {1'b0, a} + {1'b0, b};
                alu_z       = sum[WIDTH-1:0];
                alu_f.carry = sum[WIDTH];
                alu_f.ov    = (a[WIDTH-1] == b[WIDTH-1]) && (alu_z[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_z       = a - b;
                alu_f.carry = (a < b);
                alu_f.ov    = (a[WIDTH-1] != b[WIDTH-1]) && (alu_z[WIDTH-1] != a[WIDTH-1]);
            end
            // MUL never completes here: it is either iterative or illegal.
            OP_MUL:  alu_f.err = 1'b1;
            default: alu_f.err = 1'b1;
        endcase
        alu_f.sign = alu_z[WIDTH-1];
        alu_f.zero = (alu_z == '0);
    end

    // Next-state and result-register load decisions.
    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) begin
                        state_d = S_BUSY;
                    end else begin
                        z_d     = alu_z;
                        flags_d = alu_f;
                        state_d = S_HOLD;
                    end
`else
                    z_d     = alu_z;
                    flags_d = alu_f;
                    state_d = S_HOLD;
`endif
                end
            end
            S_BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    z_d     = mul_prod[WIDTH-1:0];
                    flags_d = mul_f;
                    state_d = S_HOLD;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything and drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            z_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            flags_q <= flags_d;
        end
    end

    assign z     = z_q;
    assign carry = flags_q.carry;
    assign sign  = flags_q.sign;
    assign ov    = flags_q.ov;
    assign zero  = flags_q.zero;
    assign err   = flags_q.err;

endmodule
